// File: rtl/zuc_eea3_cipher.sv
// 128-EEA3 confidentiality stage: drives zuc_core and XORs its keystream onto packet data.
// Optional build macro ZUC_EEA3_ABORT_EN adds an i_abort input that cancels a packet in flight.
module zuc_eea3_cipher #(
  parameter int LEN_W    = 32,
  parameter int INIT_CYC = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [127:0]     i_ck,
  input  logic [31:0]      i_count,
  input  logic [4:0]       i_bearer,
  input  logic             i_direction,
  input  logic [LEN_W-1:0] i_length,
`ifdef ZUC_EEA3_ABORT_EN
  input  logic             i_abort,
`endif
  output logic             o_busy,
  output logic             o_core_init,
  output logic [127:0]     o_core_key,
  output logic [127:0]     o_core_iv,
  output logic             o_core_ready,
  input  logic             i_core_valid,
  input  logic [31:0]      i_core_data,
  input  logic             i_din_valid,
  output logic             o_din_ready,
  input  logic [31:0]      i_din,
  output logic             o_dout_valid,
  input  logic             i_dout_ready,
  output logic [31:0]      o_dout,
  output logic             o_dout_last,
  output logic             o_done
);

  localparam int CNT_W  = LEN_W - 4;
  localparam int INIT_W = $clog2(INIT_CYC + 1);

  typedef enum logic [2:0] {IDLE, INIT, STREAM, DRAIN, DONE} state_e;

  state_e             state_q, state_d;
  logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]   last_idx_q, last_idx_d;
  logic [4:0]         tail_q, tail_d;
  logic [127:0]       key_q, key_d;
  logic [127:0]       iv_q, iv_d;
  logic [31:0]        dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               dout_last_q, dout_last_d;

  logic               abort_hit;
  logic               can_load;
  logic               in_stream;
  logic               xfer;
  logic               is_last;
  logic [31:0]        tail_mask;
  logic [CNT_W-1:0]   nwords;

`ifdef ZUC_EEA3_ABORT_EN
  assign abort_hit = i_abort & ((state_q == INIT) | (state_q == STREAM) | (state_q == DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  // Ready depends on valid, never the reverse, so both sides are consumed in the same cycle.
  assign can_load     = !dout_valid_q | i_dout_ready;
  assign in_stream    = (state_q == STREAM) & !abort_hit;
  assign o_core_ready = in_stream & i_din_valid & can_load;
  assign o_din_ready  = in_stream & i_core_valid & can_load;
  assign xfer         = in_stream & i_core_valid & i_din_valid & can_load;
  assign is_last      = (word_cnt_q == last_idx_q);
  assign tail_mask    = (tail_q == 5'd0) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> tail_q);
  assign nwords       = CNT_W'(i_length[LEN_W-1:5]) + CNT_W'(|i_length[4:0]);

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_start) state_d = (i_length == '0) ? DONE : INIT;
      INIT:    if (init_cnt_q == INIT_W'(INIT_CYC - 1)) state_d = STREAM;
      STREAM:  if (xfer && is_last) state_d = DRAIN;
      DRAIN:   if (dout_valid_q && i_dout_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) state_d = IDLE;
  end

  always_comb begin
    o_busy      = (state_q != IDLE);
    o_core_init = (state_q == INIT);
    o_done      = (state_q == DONE);
  end

  always_comb begin
    init_cnt_d   = (state_q == INIT) ? init_cnt_q + INIT_W'(1) : '0;
    word_cnt_d   = word_cnt_q;
    last_idx_d   = last_idx_q;
    tail_d       = tail_q;
    key_d        = key_q;
    iv_d         = iv_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;

    if (state_q == IDLE && i_start) begin
      key_d      = i_ck;
      iv_d       = {i_count, i_bearer, i_direction, 2'b00, 24'h0,
                    i_count, i_bearer, i_direction, 2'b00, 24'h0};
      tail_d     = i_length[4:0];
      last_idx_d = nwords - CNT_W'(1);
      word_cnt_d = '0;
    end

    if (xfer) begin
      dout_d       = (i_din ^ i_core_data) & (is_last ? tail_mask : 32'hFFFF_FFFF);
      dout_valid_d = 1'b1;
      dout_last_d  = is_last;
      word_cnt_d   = word_cnt_q + CNT_W'(1);
    end else if (i_dout_ready) begin
      dout_valid_d = 1'b0;
      dout_last_d  = 1'b0;
    end

    if (abort_hit) begin
      dout_valid_d = 1'b0;
      dout_last_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      init_cnt_q   <= '0;
      word_cnt_q   <= '0;
      last_idx_q   <= '0;
      tail_q       <= '0;
      key_q        <= '0;
      iv_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else begin
      init_cnt_q   <= init_cnt_d;
      word_cnt_q   <= word_cnt_d;
      last_idx_q   <= last_idx_d;
      tail_q       <= tail_d;
      key_q        <= key_d;
      iv_q         <= iv_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
    end
  end

  assign o_core_key   = key_q;
  assign o_core_iv    = iv_q;
  assign o_dout       = dout_q;
  assign o_dout_valid = dout_valid_q;
  assign o_dout_last  = dout_last_q;

endmodule

// File: tb/tb_zuc_eea3_cipher.sv
// Directed bench for zuc_eea3_cipher; the bench itself plays zuc_core with a fixed keystream table.
module tb_zuc_eea3_cipher;

  localparam int LEN_W = 32;
  localparam logic [127:0] CK     = 128'h173d14ba5003731d7a60049470f00a29;
  localparam logic [127:0] IV_EXP = 128'h66035492780000006603549278000000;

  logic             clk;
  logic             i_rst;
  logic             i_start;
  logic [127:0]     i_ck;
  logic [31:0]      i_count;
  logic [4:0]       i_bearer;
  logic             i_direction;
  logic [LEN_W-1:0] i_length;
`ifdef ZUC_EEA3_ABORT_EN
  logic             i_abort;
`endif
  logic             o_busy;
  logic             o_core_init;
  logic [127:0]     o_core_key;
  logic [127:0]     o_core_iv;
  logic             o_core_ready;
  logic             i_core_valid;
  logic [31:0]      i_core_data;
  logic             i_din_valid;
  logic             o_din_ready;
  logic [31:0]      i_din;
  logic             o_dout_valid;
  logic             i_dout_ready;
  logic [31:0]      o_dout;
  logic             o_dout_last;
  logic             o_done;

  zuc_eea3_cipher #(.LEN_W(LEN_W), .INIT_CYC(2)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_ck(i_ck), .i_count(i_count),
    .i_bearer(i_bearer), .i_direction(i_direction), .i_length(i_length),
`ifdef ZUC_EEA3_ABORT_EN
    .i_abort(i_abort),
`endif
    .o_busy(o_busy), .o_core_init(o_core_init), .o_core_key(o_core_key), .o_core_iv(o_core_iv),
    .o_core_ready(o_core_ready), .i_core_valid(i_core_valid), .i_core_data(i_core_data),
    .i_din_valid(i_din_valid), .o_din_ready(o_din_ready), .i_din(i_din),
    .o_dout_valid(o_dout_valid), .i_dout_ready(i_dout_ready), .o_dout(o_dout),
    .o_dout_last(o_dout_last), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ks [10];
  logic [31:0] pt [10];
  logic [31:0] out_log [10];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One packet with the bench acting as zuc_core and as data source/sink.
  task automatic run_packet(input string tag, input logic [LEN_W-1:0] len, input bit bp,
                            input bit ones, input bit poke, input int rst_at, input int abort_at);
    int nw, tail, kidx, didx, oidx, init_cyc, done_cnt, done_cyc, last_cyc, lone;
    bit finished, hold_pending, core_hs, din_hs;
    logic [31:0] held;
    logic [31:0] exp_w [10];
    nw = (int'(len) + 31) / 32;
    tail = int'(len) % 32;
    kidx = 0; didx = 0; oidx = 0; init_cyc = 0; done_cnt = 0; done_cyc = -1;
    last_cyc = -1; lone = 0; finished = 0; hold_pending = 0; held = '0;
    for (int i = 0; i < 10; i++) begin
      exp_w[i] = (ones ? 32'hFFFF_FFFF : pt[i]) ^ ks[i];
      if (i == nw - 1 && tail != 0) exp_w[i] &= ~(32'hFFFF_FFFF >> tail);
      out_log[i] = '0;
    end

    @(posedge clk); #1;
    i_ck = CK; i_count = 32'h66035492; i_bearer = 5'h0F; i_direction = 1'b0;
    i_length = len; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_ck = ~CK; i_count = 32'h0; i_bearer = 5'h0;
    check({tag, " key"}, o_core_key, CK);
    check({tag, " iv"}, o_core_iv, IV_EXP);
    check({tag, " busy"}, 128'(o_busy), 128'd1);

    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done_cnt > 0) begin
        check({tag, " done width"}, 128'(o_done), 128'd0);
        check({tag, " idle after"}, 128'(o_busy), 128'd0);
        finished = 1;
        break;
      end
      if (o_core_init) init_cyc++;
      if (o_done) begin done_cnt++; done_cyc = cyc; end
      if (hold_pending) check({tag, " stall hold"}, 128'(o_dout), 128'(held));

      i_dout_ready = bp ? (cyc % 2 == 0) : 1'b1;
      i_din_valid  = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_core_valid = bp ? ($urandom_range(0, 4) != 0) : 1'b1;
      i_din        = (didx < 10) ? (ones ? 32'hFFFF_FFFF : pt[didx]) : 32'h0;
      i_core_data  = (kidx < 10) ? ks[kidx] : 32'h0;
      i_start      = poke && (cyc == 4);
      i_rst        = (cyc == rst_at);
`ifdef ZUC_EEA3_ABORT_EN
      i_abort      = (abort_at >= 0) && (didx == abort_at);
`endif
      #1;
      core_hs = o_core_ready & i_core_valid;
      din_hs  = o_din_ready & i_din_valid;
`ifdef ZUC_EEA3_ABORT_EN
      if (i_abort) check({tag, " abort wins"}, 128'({core_hs, din_hs}), 128'd0);
`endif
      if (core_hs != din_hs) lone++;
      if (core_hs) kidx++;
      if (din_hs) didx++;
      if (o_dout_valid && i_dout_ready) begin
        if (oidx < nw) begin
          check($sformatf("%s word%0d", tag, oidx), 128'(o_dout), 128'(exp_w[oidx]));
          check($sformatf("%s last%0d", tag, oidx), 128'(o_dout_last), 128'(oidx == nw - 1));
          out_log[oidx] = o_dout;
          if (o_dout_last) last_cyc = cyc;
        end else begin
          check({tag, " extra word"}, 128'(oidx), 128'(nw));
        end
        oidx++;
      end
      hold_pending = o_dout_valid && !i_dout_ready;
      held = o_dout;
      @(posedge clk); #1;
      i_start = 1'b0;
      if (cyc == rst_at) begin
        check({tag, " rst flags"}, 128'({o_busy, o_core_init, o_core_ready, o_din_ready,
                                         o_dout_valid, o_dout_last, o_done}), 128'd0);
        check({tag, " rst dout"}, 128'(o_dout), 128'd0);
        check({tag, " rst key"}, o_core_key, 128'd0);
        check({tag, " rst iv"}, o_core_iv, 128'd0);
        i_rst = 1'b0;
        return;
      end
`ifdef ZUC_EEA3_ABORT_EN
      if (i_abort) begin
        i_abort = 1'b0;
        check({tag, " abort valid"}, 128'({o_dout_valid, o_dout_last, o_core_init}), 128'd0);
        check({tag, " abort idle"}, 128'(o_busy), 128'd0);
        for (int k = 0; k < 6; k++) begin
          if (o_done) done_cnt++;
          @(posedge clk); #1;
        end
        check({tag, " abort no done"}, 128'(done_cnt), 128'd0);
        return;
      end
`endif
    end

    if (!finished) check({tag, " timeout"}, 128'd0, 128'd1);
    check({tag, " word count"}, 128'(oidx), 128'(nw));
    check({tag, " init cycles"}, 128'(init_cyc), (len == '0) ? 128'd0 : 128'd2);
    check({tag, " lone consume"}, 128'(lone), 128'd0);
    check({tag, " done timing"}, 128'(done_cyc), (nw == 0) ? 128'd0 : 128'(last_cyc + 1));
    check({tag, " key held"}, o_core_key, CK);
  endtask

  initial begin
    ks = '{32'h9A6CC3F1, 32'h3B1A6F90, 32'h5D2E4C11, 32'hC0FFEE01, 32'h0BADF00D,
           32'h7E57AB1E, 32'hF0F00F0F, 32'h13579BDF, 32'h2468ACE0, 32'hDEADBEEF};
    pt = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98,
           32'h76543210, 32'h12345678, 32'h0F1E2D3C, 32'h4B5A6978, 32'h8796A5B4};
    i_rst = 1'b1; i_start = 1'b0; i_ck = '0; i_count = '0; i_bearer = '0;
    i_direction = 1'b0; i_length = '0; i_core_valid = 1'b0; i_core_data = '0;
    i_din_valid = 1'b0; i_din = '0; i_dout_ready = 1'b0;
`ifdef ZUC_EEA3_ABORT_EN
    i_abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset flags", 128'({o_busy, o_core_init, o_core_ready, o_din_ready,
                               o_dout_valid, o_dout_last, o_done}), 128'd0);
    check("reset dout", 128'(o_dout), 128'd0);
    check("reset key", o_core_key, 128'd0);
    check("reset iv", o_core_iv, 128'd0);
    i_rst = 1'b0;

    run_packet("len193", 193, 0, 0, 0, -1, -1);
    check("len193 tail const", 128'(out_log[6]), 128'h80000000);

    run_packet("len33", 33, 0, 1, 0, -1, -1);
    check("len33 out0 const", 128'(out_log[0]), 128'h65933C0E);
    check("len33 out1 const", 128'(out_log[1]), 128'h80000000);

    run_packet("len64", 64, 0, 1, 0, -1, -1);
    check("len64 out1 const", 128'(out_log[1]), 128'hC4E5906F);

    run_packet("bp320", 320, 1, 0, 0, -1, -1);
    run_packet("len0", 0, 0, 0, 0, -1, -1);
    run_packet("poke", 193, 0, 0, 1, -1, -1);
    run_packet("rst", 320, 0, 0, 0, 6, -1);
    run_packet("after rst", 64, 0, 0, 0, -1, -1);
`ifdef ZUC_EEA3_ABORT_EN
    run_packet("abort", 320, 0, 0, 0, -1, 3);
    run_packet("after abort", 193, 0, 0, 0, -1, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
